// File: rtl/alu_req_sched_if.sv
// ---------------------------------------------------------------------------
// alu_req_sched_if
// Bundles the requester, ALU and response signals of alu_req_sched.
//   master : requesters + ALU + response consumer (drives req/op/a/b,
//            alu_out, rsp_ready; observes gnt, ALU drive, response, busy)
//   slave  : the scheduler itself
// Parameters: DW = operand/result width, OPW = opcode width.
// ---------------------------------------------------------------------------
interface alu_req_sched_if #(
    parameter int DW  = 4,
    parameter int OPW = 3
);
    logic           req0, req1;
    logic [OPW-1:0] op0, op1;
    logic [DW-1:0]  a0, a1, b0, b1;
    logic           gnt0, gnt1;
    logic [OPW-1:0] alu_op;
    logic [DW-1:0]  alu_in1, alu_in2;
    logic [DW-1:0]  alu_out;
    logic           rsp_valid;
    logic           rsp_id;
    logic [DW-1:0]  rsp_data;
    logic           rsp_ready;
    logic           busy;

    modport master (
        output req0, req1, op0, op1, a0, a1, b0, b1, alu_out, rsp_ready,
        input  gnt0, gnt1, alu_op, alu_in1, alu_in2, rsp_valid, rsp_id,
               rsp_data, busy
    );

    modport slave (
        input  req0, req1, op0, op1, a0, a1, b0, b1, alu_out, rsp_ready,
        output gnt0, gnt1, alu_op, alu_in1, alu_in2, rsp_valid, rsp_id,
               rsp_data, busy
    );
endinterface

// File: rtl/alu_req_sched.sv
// ---------------------------------------------------------------------------
// alu_req_sched
// Round-robin scheduler sharing one combinational ALU between two requesters.
// A winner's opcode/operands are latched onto the ALU drive registers, the
// ALU result is captured one cycle later and returned with a valid/ready
// response tagged by requester ID. One operation in flight at most.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_req_sched_if.slave (requests, grants, ALU drive/result,
//          response handshake, busy)
// ---------------------------------------------------------------------------
module alu_req_sched #(
    parameter int DW  = 4,
    parameter int OPW = 3
) (
    input  logic           clk,
    input  logic           rst,
    alu_req_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_q, state_d;
    logic           last_q, last_d;
    logic           gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic [OPW-1:0] op_q, op_d;
    logic [DW-1:0]  in1_q, in1_d, in2_q, in2_d;
    logic [DW-1:0]  data_q, data_d;
    logic           valid_q, valid_d;
    logic           id_q, id_d;
    logic           win;

    // Lone requester wins; on a tie the one not granted last wins.
    always_comb win = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        op_d    = op_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        data_d  = data_q;
        valid_d = valid_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                    last_d  = win;
                    id_d    = win;
                    op_d    = win ? bus.op1 : bus.op0;
                    in1_d   = win ? bus.a1  : bus.a0;
                    in2_d   = win ? bus.b1  : bus.b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // ALU inputs have been stable for a full cycle here.
                data_d  = bus.alu_out;
                valid_d = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            op_q    <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            op_q    <= op_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.alu_op    = op_q;
    assign bus.alu_in1   = in1_q;
    assign bus.alu_in2   = in2_q;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = data_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_alu_req_sched.sv
// ---------------------------------------------------------------------------
// tb_alu_req_sched
// Directed scenarios followed by a randomized phase. A transaction-level
// reference model (grant winner, operand capture, result prediction from the
// operands, response hold until accepted) is compared with every DUT output
// on each falling edge; scenario-specific constants are checked on top.
// ---------------------------------------------------------------------------
module tb_alu_req_sched;
    localparam int DW  = 4;
    localparam int OPW = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    alu_req_sched_if #(.DW(DW), .OPW(OPW)) bif ();
    alu_req_sched #(.DW(DW), .OPW(OPW)) dut (.clk(clk), .rst(rst), .bus(bif));

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_ref(input logic [OPW-1:0] op,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a ^ b;
            3'b011:  return a + b;
            default: return '0;
        endcase
    endfunction

    // The shared ALU.
    assign bif.alu_out = alu_ref(bif.alu_op, bif.alu_in1, bif.alu_in2);

    // Reference model: one operation at a time; granted -> result due next
    // edge -> held until accepted.
    logic           m_last, m_busy, m_resp, m_gnt0, m_gnt1, m_valid, m_id;
    logic [OPW-1:0] m_op;
    logic [DW-1:0]  m_a, m_b, m_data;

    always @(posedge clk) begin
        if (rst) begin
            m_last <= 1'b1; m_busy <= 1'b0; m_resp <= 1'b0;
            m_gnt0 <= 1'b0; m_gnt1 <= 1'b0; m_valid <= 1'b0; m_id <= 1'b0;
            m_op <= '0; m_a <= '0; m_b <= '0; m_data <= '0;
        end else begin
            m_gnt0 <= 1'b0;
            m_gnt1 <= 1'b0;
            if (!m_busy) begin
                if (bif.req1 && (!bif.req0 || m_last == 1'b0)) begin
                    m_gnt1 <= 1'b1; m_last <= 1'b1; m_id <= 1'b1;
                    m_op <= bif.op1; m_a <= bif.a1; m_b <= bif.b1;
                    m_busy <= 1'b1;
                end else if (bif.req0) begin
                    m_gnt0 <= 1'b1; m_last <= 1'b0; m_id <= 1'b0;
                    m_op <= bif.op0; m_a <= bif.a0; m_b <= bif.b0;
                    m_busy <= 1'b1;
                end
            end else if (!m_resp) begin
                m_resp  <= 1'b1;
                m_valid <= 1'b1;
                m_data  <= alu_ref(m_op, m_a, m_b);
            end else if (bif.rsp_ready) begin
                m_resp  <= 1'b0;
                m_busy  <= 1'b0;
                m_valid <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("gnt0",      32'(bif.gnt0),      32'(m_gnt0));
        chk("gnt1",      32'(bif.gnt1),      32'(m_gnt1));
        chk("gnt_excl",  32'(bif.gnt0 & bif.gnt1), 32'(0));
        chk("rsp_valid", 32'(bif.rsp_valid), 32'(m_valid));
        chk("rsp_id",    32'(bif.rsp_id),    32'(m_id));
        chk("rsp_data",  32'(bif.rsp_data),  32'(m_data));
        chk("busy",      32'(bif.busy),      32'(m_busy));
        chk("alu_op",    32'(bif.alu_op),    32'(m_op));
        chk("alu_in1",   32'(bif.alu_in1),   32'(m_a));
        chk("alu_in2",   32'(bif.alu_in2),   32'(m_b));
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bif.req0 = 1'b0;
        bif.req1 = 1'b0;
        tick();
        chk("rst_busy",  32'(bif.busy),      32'(0));
        chk("rst_valid", 32'(bif.rsp_valid), 32'(0));
        chk("rst_data",  32'(bif.rsp_data),  32'(0));
        chk("rst_gnt",   32'({bif.gnt1, bif.gnt0}), 32'(0));
        chk("rst_aluop", 32'(bif.alu_op),    32'(0));
        rst = 1'b0;
    endtask

    initial begin
        int ng;
        int lastg;
        rst = 1'b1;
        bif.req0 = 1'b0; bif.req1 = 1'b0;
        bif.op0 = '0; bif.op1 = '0;
        bif.a0 = '0; bif.a1 = '0; bif.b0 = '0; bif.b1 = '0;
        bif.rsp_ready = 1'b0;

        // Single request
        apply_reset();
        bif.rsp_ready = 1'b1;
        bif.req0 = 1'b1; bif.op0 = 3'b010; bif.a0 = 4'b1010; bif.b0 = 4'b0110;
        tick();
        chk("single_gnt0", 32'(bif.gnt0), 32'(1));
        chk("single_busy", 32'(bif.busy), 32'(1));
        bif.req0 = 1'b0;
        tick();
        chk("single_valid", 32'(bif.rsp_valid), 32'(1));
        chk("single_id",    32'(bif.rsp_id),    32'(0));
        chk("single_data",  32'(bif.rsp_data),  32'(4'b1100));
        tick();
        chk("single_valid_low", 32'(bif.rsp_valid), 32'(0));

        // Tie round-robin
        apply_reset();
        bif.op1 = 3'b000; bif.a1 = 4'hF; bif.b1 = 4'h3;
        bif.req0 = 1'b1; bif.req1 = 1'b1;
        ng = 0; lastg = -10;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bif.gnt0 || bif.gnt1) begin
                chk("tie_winner", 32'(bif.gnt1), 32'(ng % 2));
                if (ng > 0) chk("tie_gap", 32'(c - lastg), 32'(3));
                lastg = c;
                ng++;
            end
            if (bif.rsp_valid && bif.rsp_id) chk("tie_rsp1", 32'(bif.rsp_data), 32'(4'h3));
        end
        chk("tie_count", 32'(ng), 32'(4));
        bif.req0 = 1'b0; bif.req1 = 1'b0;

        // Backpressure
        apply_reset();
        bif.rsp_ready = 1'b0;
        bif.req0 = 1'b1;
        tick();
        chk("bp_gnt0", 32'(bif.gnt0), 32'(1));
        bif.req0 = 1'b0; bif.req1 = 1'b1;
        tick();
        chk("bp_valid", 32'(bif.rsp_valid), 32'(1));
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_hold_valid", 32'(bif.rsp_valid), 32'(1));
            chk("bp_hold_id",    32'(bif.rsp_id),    32'(0));
            chk("bp_hold_data",  32'(bif.rsp_data),  32'(4'hC));
            chk("bp_no_gnt1",    32'(bif.gnt1),      32'(0));
        end
        bif.rsp_ready = 1'b1;
        tick();
        chk("bp_release_valid", 32'(bif.rsp_valid), 32'(0));
        chk("bp_release_gnt1",  32'(bif.gnt1),      32'(0));
        tick();
        chk("bp_gnt1", 32'(bif.gnt1), 32'(1));
        bif.req1 = 1'b0;
        tick();
        chk("bp_rsp1", 32'(bif.rsp_data), 32'(4'h3));
        tick();

        // Mid-operation reset
        apply_reset();
        bif.req0 = 1'b1;
        tick();
        chk("mr_gnt0", 32'(bif.gnt0), 32'(1));
        bif.req0 = 1'b0;
        rst = 1'b1;
        tick();
        chk("mr_busy",  32'(bif.busy),      32'(0));
        chk("mr_valid", 32'(bif.rsp_valid), 32'(0));
        chk("mr_id",    32'(bif.rsp_id),    32'(0));
        chk("mr_in1",   32'(bif.alu_in1),   32'(0));
        rst = 1'b0;
        tick();
        chk("mr_no_rsp", 32'(bif.rsp_valid), 32'(0));
        bif.req0 = 1'b1; bif.req1 = 1'b1;
        tick();
        chk("mr_tie_gnt0", 32'(bif.gnt0), 32'(1));
        chk("mr_tie_gnt1", 32'(bif.gnt1), 32'(0));
        bif.req0 = 1'b0; bif.req1 = 1'b0;
        repeat (3) tick();

        // Late request arriving during EXEC
        bif.req0 = 1'b1;
        tick();
        chk("late_gnt0", 32'(bif.gnt0), 32'(1));
        bif.req0 = 1'b0; bif.req1 = 1'b1;
        tick();
        chk("late_exec_gnt1", 32'(bif.gnt1), 32'(0));
        tick();
        chk("late_resp_gnt1", 32'(bif.gnt1), 32'(0));
        tick();
        chk("late_gnt1", 32'(bif.gnt1), 32'(1));
        bif.req1 = 1'b0;
        repeat (3) tick();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            if (!bif.req0 && $urandom_range(2) == 0) begin
                bif.req0 = 1'b1;
                bif.op0 = OPW'($urandom_range(3));
                bif.a0 = DW'($urandom); bif.b0 = DW'($urandom);
            end
            if (!bif.req1 && $urandom_range(2) == 0) begin
                bif.req1 = 1'b1;
                bif.op1 = OPW'($urandom_range(3));
                bif.a1 = DW'($urandom); bif.b1 = DW'($urandom);
            end
            bif.rsp_ready = ($urandom_range(3) != 0);
            rst = ($urandom_range(40) == 0);
            tick();
            if (bif.gnt0 && $urandom_range(1) == 0) bif.req0 = 1'b0;
            if (bif.gnt1 && $urandom_range(1) == 0) bif.req1 = 1'b0;
        end
        rst = 1'b0;
        bif.req0 = 1'b0; bif.req1 = 1'b0; bif.rsp_ready = 1'b1;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
